// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared definitions for the Pong command scheduler and video
//                path: default geometry, opcode values, status-word bit
//                positions, command FSM state type and small helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Geometry and game defaults shared with the video datapath
  localparam int PONG_V_RES     = 480;
  localparam int PONG_BAR_HALF  = 40;
  localparam int PONG_Y_INIT    = 240;
  localparam int PONG_WIN_SCORE = 10;

  // Command opcodes carried in dataa[31:29]; 5..7 are illegal
  localparam logic [2:0] OP_STATUS = 3'd0;
  localparam logic [2:0] OP_STAGE1 = 3'd1;
  localparam logic [2:0] OP_STAGE2 = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_PAUSE  = 3'd4;

  // Status word bit positions
  localparam int RES_ERR       = 31;
  localparam int RES_PAUSED    = 30;
  localparam int RES_PEND1     = 29;
  localparam int RES_PEND2     = 28;
  localparam int RES_GAME_OVER = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } cmd_state_e;

  // Saturate a requested bar centre into the legal [lo, hi] window
  function automatic logic [9:0] clamp_y(input logic [9:0] y,
                                         input logic [9:0] lo,
                                         input logic [9:0] hi);
    logic [9:0] r;
    r = y;
    if (y < lo) r = lo;
    else if (y > hi) r = hi;
    return r;
  endfunction

  function automatic logic [31:0] pack_status(input logic       err,
                                              input logic       paused,
                                              input logic       pend1,
                                              input logic       pend2,
                                              input logic       game_over,
                                              input logic [7:0] score2,
                                              input logic [7:0] score1);
    logic [31:0] s;
    s                = '0;
    s[RES_ERR]       = err;
    s[RES_PAUSED]    = paused;
    s[RES_PEND1]     = pend1;
    s[RES_PEND2]     = pend2;
    s[RES_GAME_OVER] = game_over;
    s[15:8]          = score2;
    s[7:0]           = score1;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : pong_cmd_scheduler_if
//  Description : Nios multi-cycle custom-instruction handshake bundle.
//  Signals     : clk_en  - instruction clock enable (CPU -> scheduler)
//                start   - command start pulse      (CPU -> scheduler)
//                dataa   - 32-bit command word      (CPU -> scheduler)
//                done    - completion pulse         (scheduler -> CPU)
//                result  - 32-bit status word       (scheduler -> CPU)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pong_cmd_scheduler_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;

  modport master (output clk_en, output start, output dataa,
                  input  done,   input  result);
  modport slave  (input  clk_en, input  start, input  dataa,
                  output done,   output result);
endinterface
`default_nettype wire

// File: rtl/pong_score_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pong_score_counter
//  Description : 8-bit player score with synchronous clear, gated increment
//                and a one-cycle flag on the increment that reaches WIN_SCORE.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                inc         - point scored this cycle
//                clr         - clear to zero (wins over inc)
//                en          - increment allowed (not paused, not game over)
//                count       - registered score
//                count_next  - score as it will be after this edge
//                win_hit     - this edge takes the score to WIN_SCORE
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_score_counter #(
  parameter int WIN_SCORE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] count,
  output logic [7:0] count_next,
  output logic       win_hit
);

  localparam logic [7:0] WIN_M1 = 8'(WIN_SCORE - 1);

  logic [7:0] count_q, count_d;
  logic       bump;

  always_comb begin
    bump    = inc && en && !clr;
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (bump) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign win_hit    = bump && (count_q == WIN_M1);

endmodule
`default_nettype wire

// File: rtl/pong_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pong_cmd_scheduler
//  Description : Decodes Nios custom-instruction commands, stages paddle
//                positions in shadow registers and commits them at frame end,
//                and owns score / pause / game-over state.
//  Ports       : CLK, RST_BTN  - clock, synchronous active-high reset
//                ci            - custom-instruction handshake (slave side)
//                frame_end     - one-cycle pulse at start of vertical blank
//                point_p1/p2   - one-cycle score pulses
//                yBar1/yBar2   - live bar centre lines
//                refresh       - pulse in the cycle after a commit
//                paused        - game paused
//                game_over     - a player reached WIN_SCORE
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_cmd_scheduler
  import pong_pkg::*;
#(
  parameter int V_RES     = PONG_V_RES,
  parameter int BAR_HALF  = PONG_BAR_HALF,
  parameter int Y_INIT    = PONG_Y_INIT,
  parameter int WIN_SCORE = PONG_WIN_SCORE
) (
  input  logic                       CLK,
  input  logic                       RST_BTN,
  pong_cmd_scheduler_if.slave        ci,
  input  logic                       frame_end,
  input  logic                       point_p1,
  input  logic                       point_p2,
  output logic [9:0]                 yBar1,
  output logic [9:0]                 yBar2,
  output logic                       refresh,
  output logic                       paused,
  output logic                       game_over
);

  localparam logic [9:0] Y_MIN = 10'(BAR_HALF);
  localparam logic [9:0] Y_MAX = 10'(V_RES - 1 - BAR_HALF);
  localparam logic [9:0] Y_RST = 10'(Y_INIT);

  cmd_state_e  state_q, state_d;
  logic [2:0]  cmd_op_q, cmd_op_d;
  logic [9:0]  cmd_y_q, cmd_y_d;
  logic [9:0]  ybar1_q, ybar1_d, ybar2_q, ybar2_d;
  logic [9:0]  shadow1_q, shadow1_d, shadow2_q, shadow2_d;
  logic        pend1_q, pend1_d, pend2_q, pend2_d;
  logic        refresh_q, refresh_d;
  logic        paused_q, paused_d;
  logic        game_over_q, game_over_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic        exec_fire;
  logic        score_clr;
  logic        score_en;
  logic        cmd_err;
  logic [9:0]  y_clamped;
  logic [7:0]  score1, score1_next, score2, score2_next;
  logic        win1, win2;
  logic        unused_dataa_bits;

  // Only opcode and y/pause field are ever consumed from the command word
  assign unused_dataa_bits = ^ci.dataa[28:10];

  assign exec_fire = (state_q == ST_EXEC) && ci.clk_en;
  assign score_clr = exec_fire && (cmd_op_q == OP_CLEAR);
  assign score_en  = !paused_q && !game_over_q;
  assign cmd_err   = cmd_op_q > OP_PAUSE;
  assign y_clamped = clamp_y(cmd_y_q, Y_MIN, Y_MAX);

  pong_score_counter #(.WIN_SCORE(WIN_SCORE)) u_score1 (
    .clk        (CLK),
    .rst        (RST_BTN),
    .inc        (point_p1),
    .clr        (score_clr),
    .en         (score_en),
    .count      (score1),
    .count_next (score1_next),
    .win_hit    (win1)
  );

  pong_score_counter #(.WIN_SCORE(WIN_SCORE)) u_score2 (
    .clk        (CLK),
    .rst        (RST_BTN),
    .inc        (point_p2),
    .clr        (score_clr),
    .en         (score_en),
    .count      (score2),
    .count_next (score2_next),
    .win_hit    (win2)
  );

  always_comb begin
    state_d     = state_q;
    cmd_op_d    = cmd_op_q;
    cmd_y_d     = cmd_y_q;
    ybar1_d     = ybar1_q;
    ybar2_d     = ybar2_q;
    shadow1_d   = shadow1_q;
    shadow2_d   = shadow2_q;
    pend1_d     = pend1_q;
    pend2_d     = pend2_q;
    paused_d    = paused_q;
    game_over_d = game_over_q;
    done_d      = 1'b0;
    result_d    = result_q;
    refresh_d   = frame_end && (pend1_q || pend2_q);

    // Commit reads the shadows as they were before this cycle's staging, so a
    // coincident stage lands in the shadow and stays pending for next frame.
    if (frame_end && pend1_q) begin
      ybar1_d = shadow1_q;
      pend1_d = 1'b0;
    end
    if (frame_end && pend2_q) begin
      ybar2_d = shadow2_q;
      pend2_d = 1'b0;
    end

    if (exec_fire) begin
      case (cmd_op_q)
        OP_STATUS: ;
        OP_STAGE1: begin
          shadow1_d = y_clamped;
          pend1_d   = 1'b1;
        end
        OP_STAGE2: begin
          shadow2_d = y_clamped;
          pend2_d   = 1'b1;
        end
        OP_PAUSE:  paused_d = cmd_y_q[0];
        default:   ;
      endcase
    end

    // Clear beats a coincident winning point; a win always forces pause
    if (score_clr) begin
      game_over_d = 1'b0;
    end else if (win1 || win2) begin
      game_over_d = 1'b1;
      paused_d    = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ci.clk_en && ci.start) begin
          state_d  = ST_EXEC;
          cmd_op_d = ci.dataa[31:29];
          cmd_y_d  = ci.dataa[9:0];
        end
      end
      ST_EXEC: begin
        if (ci.clk_en) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          // Status reflects the state after this command's effect
          result_d = pack_status(cmd_err, paused_d, pend1_d, pend2_d,
                                 game_over_d, score2_next, score1_next);
        end
      end
      ST_DONE: begin
        if (ci.clk_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      state_q     <= ST_IDLE;
      cmd_op_q    <= '0;
      cmd_y_q     <= '0;
      ybar1_q     <= Y_RST;
      ybar2_q     <= Y_RST;
      shadow1_q   <= Y_RST;
      shadow2_q   <= Y_RST;
      pend1_q     <= 1'b0;
      pend2_q     <= 1'b0;
      refresh_q   <= 1'b0;
      paused_q    <= 1'b0;
      game_over_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_op_q    <= cmd_op_d;
      cmd_y_q     <= cmd_y_d;
      ybar1_q     <= ybar1_d;
      ybar2_q     <= ybar2_d;
      shadow1_q   <= shadow1_d;
      shadow2_q   <= shadow2_d;
      pend1_q     <= pend1_d;
      pend2_q     <= pend2_d;
      refresh_q   <= refresh_d;
      paused_q    <= paused_d;
      game_over_q <= game_over_d;
      done_q      <= done_d;
      result_q    <= result_d;
    end
  end

  assign ci.done   = done_q;
  assign ci.result = result_q;
  assign yBar1     = ybar1_q;
  assign yBar2     = ybar2_q;
  assign refresh   = refresh_q;
  assign paused    = paused_q;
  assign game_over = game_over_q;

endmodule
`default_nettype wire

// File: doc/pong_cmd_scheduler.md
Name: pong_cmd_scheduler

Overview:
Controller between the Nios custom-instruction port and the Pong video datapath. It decodes 32-bit commands and stages paddle positions in shadow registers. Staged positions are committed atomically to the live bar coordinates only at frame end, so bars never tear mid-frame. It also owns the score/pause/game-over state and returns a status word through the multi-cycle custom-instruction handshake (start/done/result).

Parameters:
V_RES, 480, visible lines; used for clamping.
BAR_HALF, 40, half paddle height in lines; legal bar centre y is BAR_HALF..V_RES-1-BAR_HALF (40..439).
Y_INIT, 240, reset/centre position of both bars.
WIN_SCORE, 10, score at which game_over is set.

Ports:
CLK  in  1  system clock.
RST_BTN  in  1  reset; synchronous, active-high.
clk_en  in  1  custom-instruction clock enable; when low, the command FSM holds its state.
start  in  1  custom-instruction start pulse; sampled only when clk_en=1.
dataa  in  32  command word: [31:29] opcode, [9:0] y value, [0] pause flag.
frame_end  in  1  one-CLK pulse at the start of vertical blank.
point_p1  in  1  one-CLK pulse: player 1 scored.
point_p2  in  1  one-CLK pulse: player 2 scored.
done  out  1  one-cycle completion pulse.
result  out  32  status word.
yBar1  out  10  live bar-1 centre y.
yBar2  out  10  live bar-2 centre y.
refresh  out  1  one-cycle pulse in the cycle after a commit.
paused  out  1  game paused.
game_over  out  1  a player has reached WIN_SCORE.

Behaviour:
- Reset values (synchronous, RST_BTN=1 at a CLK edge): yBar1=yBar2=shadow1=shadow2=Y_INIT, pend1=pend2=0, refresh=0, done=0, result=0, paused=0, game_over=0, both scores=0, FSM=IDLE. Reset mid-command aborts the command with no done pulse.
- Opcodes: 0 = status read (no side effect); 1 = stage bar1 y; 2 = stage bar2 y; 3 = clear scores and game_over (paused unchanged); 4 = paused<=dataa[0]. Opcodes 5-7 are illegal: no side effect, err=1.
- Clamp on staging: y<BAR_HALF -> BAR_HALF; y>V_RES-1-BAR_HALF -> V_RES-1-BAR_HALF; values are 10-bit unsigned.
- Command FSM (advances only when clk_en=1):
  - IDLE: start=1 -> EXEC, latch dataa.
  - EXEC: apply the opcode (shadow write and pendN<=1, score clear, or pause update), then -> DONE.
  - DONE: done=1 for exactly one cycle; result updated this cycle; -> IDLE.
  - Latency from the start edge to done is 2 enabled cycles. start outside IDLE is ignored. result holds its value until the next DONE.
- result layout: [31] err, [30] paused, [29] pend1, [28] pend2, [27] game_over, [26:16] 0, [15:8] score2, [7:0] score1. Pending, pause, game_over and score fields reflect state after the command's effect.
- Commit (independent of clk_en): frame_end=1 and pendN=1 -> yBarN<=shadowN, pendN<=0; refresh=1 in the next cycle if any bar was committed. frame_end with nothing pending produces no refresh.
- Simultaneous frame_end and EXEC staging the same bar: the commit uses the old shadow value; the new value is written to shadow and pendN remains 1 for the next frame.
- Scores: 8-bit counters. Increment on point_pN only when paused=0 and game_over=0. point_p1 and point_p2 in the same cycle both increment. When a score reaches WIN_SCORE: game_over<=1 and paused<=1 in the same cycle. Opcode 3 in the same cycle as a point pulse: the clear wins.
- An opcode 4 that clears pause while game_over=1 sets paused=0, but scoring remains blocked until opcode 3.

Decomposition:
- Shared package pong_pkg: opcode constants (OP_STATUS..OP_PAUSE), result bit indices, V_RES/Y_INIT defaults shared with the video path.
- One sub-module, pong_score_counter: an 8-bit counter with increment, clear and enable, plus a reached-WIN_SCORE flag. Instantiated twice.

Test Plan:
- Reset, then opcode 0 with clk_en=1 -> done 2 cycles after start, result=0x00000000, yBar1=yBar2=240.
- Opcode 1 with y=100, no frame_end -> yBar1 stays 240, result[29]=1; next frame_end -> yBar1=100 and refresh pulses in the following cycle, pend1=0.
- Opcode 2 with y=5, then with y=1000 -> staged 40 and 439 respectively; after frame_end, yBar2=439.
- EXEC of opcode 1 (y=300) coincident with frame_end while shadow1=100 pending -> yBar1=100, pend1 stays 1; next frame_end -> yBar1=300.
- Ten point_p1 pulses, with one also coincident with point_p2 -> score1=10, score2=1, game_over=1, paused=1; a further point_p1 leaves score1 at 10; opcode 3 -> scores 0, game_over 0, paused 1.
- Opcode 6 -> done pulses, result[31]=1, no state change; start held while in EXEC, or with clk_en=0, -> ignored (no extra done).
